// File: rtl/dshot_rx_array.sv
// N-channel DShot receiver: per-channel synchroniser, high-time bit decoder, CRC check,
// throttle-to-speed mapping and failsafe timeout, driving a flattened speed bus.
module dshot_rx_array #(
    parameter int CHANNELS    = 8,
    parameter int SPEED_W     = 8,
    parameter int CLK_HZ      = 16000000,
    parameter int DSHOT_RATE  = 150000,
    parameter int TIMEOUT_CYC = 1600000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          dshot_in,
    output logic [CHANNELS*SPEED_W-1:0]  speed_flat,
    output logic [CHANNELS-1:0]          frame_valid,
    output logic [CHANNELS-1:0]          crc_err,
    output logic [CHANNELS-1:0]          chan_alive,
    output logic [CHANNELS-1:0]          telem_req,
    output logic                         any_active
);

    localparam int BIT_CYC  = CLK_HZ / DSHOT_RATE;
    localparam int THRESH   = BIT_CYC / 2;
    localparam int MIN_HIGH = BIT_CYC / 8;
    localparam int GAP_CYC  = 2 * BIT_CYC;
    localparam int HI_MAX   = 2 * BIT_CYC;
    localparam int LO_MAX   = GAP_CYC + 1;
    localparam int CW       = $clog2(LO_MAX + 1);
    localparam int TW       = $clog2(TIMEOUT_CYC + 1);
    localparam int SHIFT    = 11 - SPEED_W;

    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_HIGH);
    localparam logic [CW-1:0] GAP_C    = CW'(GAP_CYC);
    localparam logic [CW-1:0] HI_MAX_C = CW'(HI_MAX);
    localparam logic [CW-1:0] LO_MAX_C = CW'(LO_MAX);
    localparam logic [TW-1:0] TO_C     = TW'(TIMEOUT_CYC);

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_meta, rst_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta <= 1'b1;
            rst_sync <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_sync <= rst_meta;
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic          sync_a, sync_b, sync_prev;
            logic [CW-1:0] hi_cnt, lo_cnt;
            logic [14:0]   shift;
            logic [4:0]    bit_cnt;
            logic          done;
            logic [15:0]   frame;
            logic [TW-1:0] to_cnt;
            logic [SPEED_W-1:0] speed;
            logic          alive, telem, fv, ce;

            logic          fall, bit_val, glitch, crc_ok, telem_bit;
            logic [11:0]   v;
            logic [10:0]   throttle;

            assign fall      = sync_prev & ~sync_b;
            assign bit_val   = (hi_cnt >= THRESH_C);
            assign glitch    = (hi_cnt < MIN_C);
            assign v         = frame[15:4];
            assign throttle  = v[11:1];
            assign telem_bit = v[0];
            assign crc_ok    = (frame[3:0] == 4'(v ^ (v >> 4) ^ (v >> 8)));

            // Front end: synchronise, measure high/low times, assemble bits into a frame.
            always_ff @(posedge clk or posedge rst_sync) begin
                if (rst_sync) begin
                    sync_a    <= 1'b0;
                    sync_b    <= 1'b0;
                    sync_prev <= 1'b0;
                    hi_cnt    <= '0;
                    lo_cnt    <= '0;
                    shift     <= '0;
                    bit_cnt   <= '0;
                    done      <= 1'b0;
                    frame     <= '0;
                end else begin
                    sync_a    <= dshot_in[ch];
                    sync_b    <= sync_a;
                    sync_prev <= sync_b;
                    hi_cnt    <= sync_b ? ((hi_cnt == HI_MAX_C) ? hi_cnt : hi_cnt + 1'b1) : '0;
                    lo_cnt    <= sync_b ? '0 : ((lo_cnt == LO_MAX_C) ? lo_cnt : lo_cnt + 1'b1);
                    done      <= 1'b0;
                    if (fall && !glitch) begin
                        if (bit_cnt == 5'd15) begin
                            frame   <= {shift, bit_val};
                            shift   <= '0;
                            bit_cnt <= '0;
                            done    <= 1'b1;
                        end else begin
                            shift   <= {shift[13:0], bit_val};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (lo_cnt > GAP_C && bit_cnt != 5'd0) begin
                        shift   <= '0;
                        bit_cnt <= '0;
                    end
                end
            end

            // Back end: accepted frames beat a same-cycle failsafe expiry.
            always_ff @(posedge clk or posedge rst_sync) begin
                if (rst_sync) begin
                    to_cnt <= '0;
                    speed  <= '0;
                    alive  <= 1'b0;
                    telem  <= 1'b0;
                    fv     <= 1'b0;
                    ce     <= 1'b0;
                end else begin
                    fv <= 1'b0;
                    ce <= 1'b0;
                    if (done && crc_ok) begin
                        fv     <= 1'b1;
                        telem  <= telem_bit;
                        alive  <= 1'b1;
                        to_cnt <= '0;
                        if (throttle == 11'd0)
                            speed <= '0;
                        else if (throttle >= 11'd48)
                            speed <= SPEED_W'((throttle - 11'd48) >> SHIFT);
                    end else begin
                        if (done)
                            ce <= 1'b1;
                        if (to_cnt != TO_C) begin
                            to_cnt <= to_cnt + 1'b1;
                            if (to_cnt == TO_C - 1'b1) begin
                                speed <= '0;
                                alive <= 1'b0;
                                telem <= 1'b0;
                            end
                        end
                    end
                end
            end

            assign speed_flat[(CHANNELS-ch)*SPEED_W-1 -: SPEED_W] = speed;
            assign frame_valid[ch] = fv;
            assign crc_err[ch]     = ce;
            assign chan_alive[ch]  = alive;
            assign telem_req[ch]   = telem;
        end
    endgenerate

    assign any_active = |speed_flat;

endmodule

// File: tb/tb_dshot_rx_array.sv
// Directed bench for dshot_rx_array: drives DShot waveforms on the pins and checks decoded
// speed, pulses, telemetry, failsafe and reset behaviour against hand-computed values.
module tb_dshot_rx_array;

    localparam int CH  = 8;
    localparam int SW  = 8;
    localparam int BIT = 106;
    localparam int TO  = 8000;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     dshot;
    logic [CH*SW-1:0]  speed_flat;
    logic [CH-1:0]     frame_valid, crc_err, chan_alive, telem_req;
    logic              any_active;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fall = 0;
    int fv_cnt[CH];
    int ce_cnt[CH];
    int fv_last[CH];
    logic [15:0] tx_word[CH];

    dshot_rx_array #(
        .CHANNELS(CH), .SPEED_W(SW), .CLK_HZ(16000000), .DSHOT_RATE(150000), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .dshot_in(dshot), .speed_flat(speed_flat),
        .frame_valid(frame_valid), .crc_err(crc_err), .chan_alive(chan_alive),
        .telem_req(telem_req), .any_active(any_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are one cycle wide, so sampling on the falling edge counts each exactly once.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (frame_valid[c]) begin
                fv_cnt[c]  = fv_cnt[c] + 1;
                fv_last[c] = cyc;
            end
            if (crc_err[c]) ce_cnt[c] = ce_cnt[c] + 1;
        end
    end

    function automatic logic [7:0] spd(input int c);
        return speed_flat[(CH-c)*SW-1 -: SW];
    endfunction

    function automatic logic [15:0] mk(input logic [10:0] thr, input logic tel);
        logic [11:0] v, x;
        v = {thr, tel};
        x = v ^ (v >> 4) ^ (v >> 8);
        return {v, x[3:0]};
    endfunction

    task automatic send(input logic [CH-1:0] mask, input int nbits, input int hi1, input int hi0);
        int hv;
        dshot = '0;
        repeat (250) @(posedge clk);
        for (int b = 0; b < nbits; b++) begin
            for (int t = 0; t < BIT; t++) begin
                @(posedge clk);
                #1;
                for (int c = 0; c < CH; c++) begin
                    hv = tx_word[c][15-b] ? hi1 : hi0;
                    dshot[c] = mask[c] && (t < hv);
                end
                if (b == nbits - 1 && t == (tx_word[0][15-b] ? hi1 : hi0)) last_fall = cyc;
            end
        end
        dshot = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dshot = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (speed_flat !== '0 || any_active !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_speed: got %h/%b expected 0/0", speed_flat, any_active);
        end
        n_checks++;
        if ({frame_valid, crc_err, chan_alive, telem_req} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %h expected 0", {frame_valid, crc_err, chan_alive, telem_req});
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame;
        int f0;
        f0 = fv_cnt[0];
        tx_word[0] = 16'h830B;
        send(8'h01, 16, 80, 40);
        n_checks++;
        if (spd(0) !== 8'd125) begin n_fail++; $display("[TB] FAIL t1_speed: got %0d expected 125", spd(0)); end
        n_checks++;
        if (chan_alive !== 8'h01) begin n_fail++; $display("[TB] FAIL t1_alive: got %b expected 00000001", chan_alive); end
        n_checks++;
        if (fv_cnt[0] - f0 !== 1) begin n_fail++; $display("[TB] FAIL t1_fv_count: got %0d expected 1", fv_cnt[0] - f0); end
        n_checks++;
        if (fv_last[0] - last_fall !== 4) begin n_fail++; $display("[TB] FAIL t1_latency: got %0d expected 4", fv_last[0] - last_fall); end
        n_checks++;
        if (telem_req[0] !== 1'b0 || any_active !== 1'b1) begin
            n_fail++; $display("[TB] FAIL t1_telem_any: got %b/%b expected 0/1", telem_req[0], any_active);
        end
    endtask

    task automatic test_full_and_zero;
        int f3, e3;
        tx_word[3] = 16'hFFEE;
        send(8'h08, 16, 80, 40);
        n_checks++;
        if (spd(3) !== 8'd249) begin n_fail++; $display("[TB] FAIL t2_full: got %0d expected 249", spd(3)); end
        f3 = fv_cnt[3];
        e3 = ce_cnt[3];
        tx_word[3] = 16'h0000;
        send(8'h08, 16, 80, 40);
        n_checks++;
        if (spd(3) !== 8'd0) begin n_fail++; $display("[TB] FAIL t2_zero: got %0d expected 0", spd(3)); end
        n_checks++;
        if (fv_cnt[3] - f3 !== 1 || ce_cnt[3] - e3 !== 0) begin
            n_fail++; $display("[TB] FAIL t2_pulses: got fv %0d ce %0d expected 1 0", fv_cnt[3] - f3, ce_cnt[3] - e3);
        end
    endtask

    task automatic test_crc_and_command;
        int f1, e1;
        tx_word[1] = 16'h830B;
        send(8'h02, 16, 80, 40);
        f1 = fv_cnt[1];
        e1 = ce_cnt[1];
        tx_word[1] = 16'h830A;
        send(8'h02, 16, 80, 40);
        n_checks++;
        if (ce_cnt[1] - e1 !== 1 || fv_cnt[1] - f1 !== 0) begin
            n_fail++; $display("[TB] FAIL t3_crc_pulses: got ce %0d fv %0d expected 1 0", ce_cnt[1] - e1, fv_cnt[1] - f1);
        end
        n_checks++;
        if (spd(1) !== 8'd125) begin n_fail++; $display("[TB] FAIL t3_crc_hold: got %0d expected 125", spd(1)); end
        tx_word[1] = 16'h00BB;
        send(8'h02, 16, 80, 40);
        n_checks++;
        if (spd(1) !== 8'd125) begin n_fail++; $display("[TB] FAIL t3_cmd_hold: got %0d expected 125", spd(1)); end
        n_checks++;
        if (telem_req[1] !== 1'b1 || fv_cnt[1] - f1 !== 1) begin
            n_fail++; $display("[TB] FAIL t3_cmd_telem: got telem %b fv %0d expected 1 1", telem_req[1], fv_cnt[1] - f1);
        end
    endtask

    task automatic test_glitch_and_gap;
        int f2, e2;
        f2 = fv_cnt[2];
        e2 = ce_cnt[2];
        tx_word[2] = 16'h830B;
        send(8'h04, 16, 10, 10);
        repeat (300) @(posedge clk);
        n_checks++;
        if (fv_cnt[2] - f2 !== 0 || ce_cnt[2] - e2 !== 0) begin
            n_fail++; $display("[TB] FAIL t4_glitch: got fv %0d ce %0d expected 0 0", fv_cnt[2] - f2, ce_cnt[2] - e2);
        end
        send(8'h04, 9, 80, 40);
        repeat (300) @(posedge clk);
        #1;
        n_checks++;
        if (fv_cnt[2] - f2 !== 0 || ce_cnt[2] - e2 !== 0) begin
            n_fail++; $display("[TB] FAIL t4_gap: got fv %0d ce %0d expected 0 0", fv_cnt[2] - f2, ce_cnt[2] - e2);
        end
        send(8'h04, 16, 80, 40);
        n_checks++;
        if (spd(2) !== 8'd125 || fv_cnt[2] - f2 !== 1 || ce_cnt[2] - e2 !== 0) begin
            n_fail++; $display("[TB] FAIL t4_recover: got %0d fv %0d ce %0d expected 125 1 0", spd(2), fv_cnt[2] - f2, ce_cnt[2] - e2);
        end
    endtask

    task automatic test_timeout;
        int t_acc;
        tx_word[0] = 16'h830B;
        send(8'h01, 16, 80, 40);
        t_acc = fv_last[0];
        n_checks++;
        if (spd(0) !== 8'd125) begin n_fail++; $display("[TB] FAIL t5_pre: got %0d expected 125", spd(0)); end
        while (cyc < t_acc + TO - 1) @(negedge clk);
        n_checks++;
        if (chan_alive[0] !== 1'b1 || spd(0) !== 8'd125) begin
            n_fail++; $display("[TB] FAIL t5_before_expiry: got alive %b speed %0d expected 1 125", chan_alive[0], spd(0));
        end
        while (cyc < t_acc + TO) @(negedge clk);
        n_checks++;
        if (chan_alive[0] !== 1'b0 || spd(0) !== 8'd0 || any_active !== 1'b0) begin
            n_fail++; $display("[TB] FAIL t5_expiry: got alive %b speed %0d any %b expected 0 0 0", chan_alive[0], spd(0), any_active);
        end
        @(posedge clk);
        #1;
        send(8'h01, 16, 80, 40);
        n_checks++;
        if (spd(0) !== 8'd125 || chan_alive[0] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL t5_restore: got %0d alive %b expected 125 1", spd(0), chan_alive[0]);
        end
    endtask

    task automatic test_reset_midframe;
        int f_before[CH];
        for (int c = 0; c < CH; c++) tx_word[c] = 16'h830B;
        send(8'hFF, 8, 80, 40);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (speed_flat !== '0 || any_active !== 1'b0 || {frame_valid, crc_err, chan_alive, telem_req} !== '0) begin
            n_fail++; $display("[TB] FAIL t6_in_reset: got %h %b %h expected all 0", speed_flat, any_active, {frame_valid, crc_err, chan_alive, telem_req});
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            f_before[c] = fv_cnt[c];
            tx_word[c]  = mk(11'(48 + 8 * (10 * c + 3)), 1'(c % 2));
        end
        send(8'hFF, 16, 80, 40);
        for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (spd(c) !== 8'(10 * c + 3) || fv_cnt[c] - f_before[c] !== 1) begin
                n_fail++; $display("[TB] FAIL t6_ch%0d: got %0d fv %0d expected %0d 1", c, spd(c), fv_cnt[c] - f_before[c], 10 * c + 3);
            end
        end
        n_checks++;
        if (telem_req !== 8'hAA || chan_alive !== 8'hFF) begin
            n_fail++; $display("[TB] FAIL t6_flags: got telem %h alive %h expected aa ff", telem_req, chan_alive);
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            fv_cnt[c]  = 0;
            ce_cnt[c]  = 0;
            fv_last[c] = 0;
            tx_word[c] = 16'h0000;
        end
        test_reset;
        test_basic_frame;
        test_full_and_zero;
        test_crc_and_command;
        test_glitch_and_gap;
        test_timeout;
        test_reset_midframe;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
